// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry circular FIFO
// carrying pc, instruction word and fetch-side exception info per entry.
module inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    input  logic             in_is_exception,
    input  logic [6:0]       in_exception_cause,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic             out_is_exception,
    output logic [6:0]       out_exception_cause,
    output logic [PTR_W:0]   count
);

    localparam int              ENTRY_W   = 72;
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ZERO  = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]  CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W:0]     count_r;

    logic               full_s;
    logic               empty_s;
    logic               push_s;
    logic               pop_s;
    logic [ENTRY_W-1:0] head_entry_s;

    // Occupancy flags and handshake qualification; flush and reset squash both directions.
    always_comb begin
        full_s  = 1'b0;
        empty_s = 1'b0;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        if (count_r == DEPTH_CNT) begin
            full_s = 1'b1;
        end else begin
            full_s = 1'b0;
        end
        if (count_r == CNT_ZERO) begin
            empty_s = 1'b1;
        end else begin
            empty_s = 1'b0;
        end
        if (rst_n && !flush) begin
            push_s = in_valid && !full_s;
            pop_s  = out_ready && !empty_s;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    // Pointer and occupancy state; reset outranks flush, which outranks push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else if (flush) begin
            head_r  <= PTR_ZERO;
            tail_r  <= PTR_ZERO;
            count_r <= CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_ONE;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= head_r + PTR_ONE;
            end else begin
                head_r <= head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage is deliberately left unreset; only qualified pushes write it.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= {in_pc, in_inst, in_is_exception, in_exception_cause};
        end
    end

    // Head entry is presented combinationally, so a new entry shows one cycle after its push.
    always_comb begin
        head_entry_s        = mem_r[head_r];
        out_pc              = head_entry_s[71:40];
        out_inst            = head_entry_s[39:8];
        out_is_exception    = head_entry_s[7];
        out_exception_cause = head_entry_s[6:0];
        out_valid           = !empty_s;
        in_ready            = !full_s && !flush;
        count               = count_r;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: a queue-based reference model of the FIFO
// contents, directed scenarios followed by randomized traffic.
module tb_inst_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  cause;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_pc = 32'd0;
    logic [31:0]      in_inst = 32'd0;
    logic             in_is_exception = 1'b0;
    logic [6:0]       in_exception_cause = 7'd0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_pc;
    logic [31:0]      out_inst;
    logic             out_is_exception;
    logic [6:0]       out_exception_cause;
    logic [PTR_W:0]   count;

    ent_t exp_q[$];
    ent_t pend_ent;
    logic pend_push = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] seq_pc = 32'h1c000000;

    inst_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .in_is_exception(in_is_exception), .in_exception_cause(in_exception_cause),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst),
        .out_is_exception(out_is_exception), .out_exception_cause(out_exception_cause),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares visible state against the model, consumes the head on a handshake.
    initial begin
        forever begin
            @(negedge clk);
            chk("count", 32'(count), 32'(exp_q.size()));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'((exp_q.size() != DEPTH) && !flush));
            if (exp_q.size() != 0) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_inst", out_inst, exp_q[0].inst);
                chk("out_exc", 32'(out_is_exception), 32'(exp_q[0].exc));
                chk("out_cause", 32'(out_exception_cause), 32'(exp_q[0].cause));
                if (out_ready && !flush && rst_n) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Model update at the clock edge: reset/flush empty it, otherwise an accepted push lands.
    always @(posedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
        end else if (pend_push) begin
            exp_q.push_back(pend_ent);
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic exc, input logic [6:0] cause,
                         input logic ordy, input logic fl, input logic rn);
        @(posedge clk);
        #1;
        in_valid = v; in_pc = pc; in_inst = inst;
        in_is_exception = exc; in_exception_cause = cause;
        out_ready = ordy; flush = fl; rst_n = rn;
        pend_ent.pc = pc; pend_ent.inst = inst; pend_ent.exc = exc; pend_ent.cause = cause;
        pend_push = v && !fl && rn && (exp_q.size() < DEPTH);
    endtask

    task automatic push_seq(input logic ordy);
        drive(1'b1, seq_pc, 32'h4c000020 + seq_pc[7:0], 1'b0, 7'd0, ordy, 1'b0, 1'b1);
        seq_pc = seq_pc + 32'd4;
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 7'd0, ordy, 1'b0, 1'b1);
    endtask

    initial begin
        drive(1'b0, 32'd0, 32'd0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        idle(1'b0, 1);

        // Three entries held, then drained in order.
        for (int i = 0; i < 3; i++) push_seq(1'b0);
        idle(1'b0, 1);
        idle(1'b1, 4);

        // Fill to full, rejected push, pop frees the slot next cycle.
        for (int i = 0; i < DEPTH; i++) push_seq(1'b0);
        drive(1'b1, 32'h1c000020, 32'h12345678, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h1c000020, 32'h12345678, 1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
        idle(1'b0, 1);
        idle(1'b1, DEPTH + 2);

        // Steady push+pop from four entries, wrapping the pointers.
        for (int i = 0; i < 4; i++) push_seq(1'b0);
        for (int i = 0; i < 20; i++) push_seq(1'b1);
        idle(1'b1, DEPTH + 1);

        // Exception flag travels only with its own instruction.
        push_seq(1'b0);
        drive(1'b1, 32'h1c000100, 32'h0badc0de, 1'b1, 7'h08, 1'b0, 1'b0, 1'b1);
        push_seq(1'b0);
        idle(1'b1, 4);

        // Flush with concurrent push and pop.
        for (int i = 0; i < 5; i++) push_seq(1'b0);
        drive(1'b1, 32'h1c000200, 32'hdeadbeef, 1'b0, 7'd0, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 2);

        // Reset mid-operation, then a push shows one cycle later.
        for (int i = 0; i < 6; i++) push_seq(1'b0);
        drive(1'b1, 32'h1c000300, 32'h11111111, 1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
        push_seq(1'b0);
        idle(1'b0, 1);
        idle(1'b1, 3);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                  1'($urandom_range(0, 9) == 0), 7'($urandom),
                  1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 3),
                  1'($urandom_range(0, 99) >= 1));
        end
        idle(1'b1, DEPTH + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of instruction entries; power of two, 2..64.
REQ-002 Parameter PTR_W, default 3, pointer width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  pipeline redirect; discards all queued entries.
REQ-006 in_valid  input  1  fetch stage presents an instruction.
REQ-007 in_ready  output  1  queue accepts an instruction this cycle.
REQ-008 in_pc  input  32  fetch PC.
REQ-009 in_inst  input  32  instruction word.
REQ-010 in_is_exception  input  1  fetch-side exception flag (ADEF/TLB/PIF) attached to the instruction.
REQ-011 in_exception_cause  input  7  fetch-side exception cause code.
REQ-012 out_valid  output  1  head entry is available to the decoder.
REQ-013 out_ready  input  1  decoder consumes the head entry this cycle.
REQ-014 out_pc  output  32  head entry PC.
REQ-015 out_inst  output  32  head entry instruction word.
REQ-016 out_is_exception  output  1  head entry fetch exception flag.
REQ-017 out_exception_cause  output  7  head entry exception cause.
REQ-018 count  output  PTR_W+1  number of valid entries, 0..DEPTH.

Function
REQ-019 Storage: DEPTH-entry circular buffer, 72 bits per entry (pc, inst, flag, cause); head/tail pointers PTR_W bits; natural wrap from DEPTH-1 to 0.
REQ-020 in_ready = (count != DEPTH) and not flush; combinational, no dependence on out_ready.
REQ-021 Push: in_valid and in_ready at a clock edge -> entry written at tail, tail+1.
REQ-022 out_valid = (count != 0); out_* driven combinationally from entry at head.
REQ-023 Pop: out_valid and out_ready at a clock edge -> head+1.
REQ-024 Simultaneous push and pop, 0 < count < DEPTH: both take effect; count unchanged.
REQ-025 Full (count == DEPTH): in_ready = 0; a pop in the same cycle frees the slot only from the next cycle (no full-bypass).
REQ-026 Empty (count == 0): out_valid = 0; out_ready ignored; no empty-bypass, so a pushed entry appears on out_* exactly 1 cycle after its push edge.
REQ-027 count updates on the same edge: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-028 flush = 1 at an edge: head, tail, count -> 0; any same-cycle push or pop is discarded; flush has priority over push and pop.
REQ-029 During a flush cycle out_valid follows count from before the flush; the decoder is responsible for ignoring it.
REQ-030 out_* with out_valid = 0: value unspecified; the decoder does not sample it.
REQ-031 Entry order preserved strictly FIFO; exception flag and cause travel with their own instruction, never with a neighbour.
REQ-032 Storage array is not reset; only pointers and count carry reset values.

Reset
REQ-033 rst_n = 0 at an edge -> head = 0, tail = 0, count = 0; takes priority over flush, push and pop.
REQ-034 Outputs while and after reset: out_valid = 0, count = 0, in_ready = 1 from the first cycle with rst_n = 1 and flush = 0.
REQ-035 Reset asserted mid-operation with entries queued: all entries lost; no pop handshake reported on that edge.

Verification
REQ-036 Push 3 entries (pc 0x1c000000/04/08, inst 0x4c000020 etc.) with out_ready = 0 -> count = 3; then out_ready = 1 -> same three pc/inst emerge in order over 3 cycles; count ends at 0.
REQ-037 Push DEPTH = 8 entries -> count = 8, in_ready = 0; drive in_valid with pc 0x1c000020 -> not accepted; pop one -> in_ready = 1 next cycle.
REQ-038 Continuous push+pop for 20 cycles from count = 4 -> count stays 4; pointers wrap past 7 with no loss or reordering.
REQ-039 Push entry with in_is_exception = 1, cause 0x08 between two clean entries -> only the middle output shows flag = 1, cause 0x08.
REQ-040 count = 5, assert flush with in_valid = 1 and out_ready = 1 -> next cycle count = 0, out_valid = 0, pushed entry absent.
REQ-041 count = 6, drive rst_n = 0 for 1 cycle -> count = 0, out_valid = 0; first push after reset appears on out_pc 1 cycle later.
